// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, parameter defaults and FSM encoding for the UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state code.
package uart_pkg;

    localparam int TICKS_PER_BIT   = 16;
    localparam int NB_DATA_DEF     = 8;
    localparam int NB_STOP_DEF     = 16;
    localparam int NC_PER_TICK_DEF = 163;
    localparam int NB_COUNTER_DEF  = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam state_t ST_PARITY = 3'd4;
`endif

    // Width that holds counts 0..max_count-1, never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/baudrate_generator.sv
// baudrate_generator: free-running oversample tick, one clk wide, every NC_PER_TICK cycles.
module baudrate_generator
    import uart_pkg::*;
#(
    parameter int NC_PER_TICK = NC_PER_TICK_DEF,
    parameter int NB_COUNTER  = NB_COUNTER_DEF
) (
    input  logic clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(NC_PER_TICK - 1);

    logic [NB_COUNTER-1:0] cnt;

    assign o_tick = (cnt == CNT_LAST);

    // Count 0..NC_PER_TICK-1 and wrap.
    always_ff @(posedge clk) begin
        if (i_rst)
            cnt <= '0;
        else
            cnt <= o_tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_top.sv
// uart_tx_top: UART transmitter, 16x oversampled, start/data(LSB first)/stop framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_top
    import uart_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int NB_STOP     = NB_STOP_DEF,
    parameter int NC_PER_TICK = NC_PER_TICK_DEF,
    parameter int NB_COUNTER  = NB_COUNTER_DEF
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start_tx,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_data,
    output logic               o_txdone,
    output logic               o_tick
);

    localparam int TICK_MAX = (NB_STOP > TICKS_PER_BIT) ? NB_STOP : TICKS_PER_BIT;
    localparam int NB_TICK  = cnt_width(TICK_MAX);
    localparam int NB_BIT   = cnt_width(NB_DATA);

    localparam logic [NB_TICK-1:0] BIT_LAST  = NB_TICK'(TICKS_PER_BIT - 1);
    localparam logic [NB_TICK-1:0] STOP_LAST = NB_TICK'(NB_STOP - 1);
    localparam logic [NB_BIT-1:0]  DATA_LAST = NB_BIT'(NB_DATA - 1);

    state_t               state;
    logic [NB_TICK-1:0]   tick_cnt;
    logic [NB_BIT-1:0]    bit_cnt;
    logic [NB_DATA-1:0]   shreg;
    logic                 win_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    baudrate_generator #(
        .NC_PER_TICK(NC_PER_TICK),
        .NB_COUNTER (NB_COUNTER)
    ) u_baud (
        .clk   (clk),
        .i_rst (i_rst),
        .o_tick(o_tick)
    );

    // A bit window closes on the tick that completes its tick count; stop has its own length.
    assign win_end = o_tick && (tick_cnt == ((state == ST_STOP) ? STOP_LAST : BIT_LAST));

    // Tick counter only runs outside IDLE, so a tick in the start-request cycle is never counted.
    always_ff @(posedge clk) begin
        if (i_rst || state == ST_IDLE)
            tick_cnt <= '0;
        else if (o_tick)
            tick_cnt <= win_end ? '0 : tick_cnt + 1'b1;
    end

    // Frame sequencer; o_data is driven from registers so the line never glitches.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            o_data   <= 1'b1;
            o_txdone <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            o_txdone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    o_data  <= !i_start_tx;
                    if (i_start_tx) begin
                        state <= ST_START;
                        shreg <= i_data;
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^i_data;
`endif
                    end
                end
                ST_START: if (win_end) begin
                    state  <= ST_DATA;
                    o_data <= shreg[0];
                end
                ST_DATA: if (win_end) begin
                    if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state  <= ST_PARITY;
                        o_data <= par_bit;
`else
                        state  <= ST_STOP;
                        o_data <= 1'b1;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= shreg >> 1;
                        o_data  <= shreg[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: if (win_end) begin
                    state  <= ST_STOP;
                    o_data <= 1'b1;
                end
`endif
                ST_STOP: if (win_end) begin
                    state    <= ST_IDLE;
                    o_txdone <= 1'b1;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_data <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top: scoreboard bench for uart_tx_top (tick, framing, timing, reset abort, back-to-back).
// Follows UART_TX_PARITY_EN for the expected frame; baud divider is scaled down to keep runs short.
module tb_uart_tx_top;

    localparam int NC  = 13;
    localparam int NBC = 4;
    localparam int NBD = 8;
    localparam int NBS = 16;
    localparam int TPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NW      = NBD + 2 + PAR;
    localparam int T_FRAME = TPB * (NW - 1) + NBS;
    localparam int TIMEOUT = 2 * T_FRAME * NC;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [NBD-1:0] data = '0;
    logic           o_data, o_txdone, o_tick;

    int n_chk = 0, n_err = 0, cyc = 0, done_cnt = 0;

    logic [NW-1:0] sb[$];
    logic [NW-1:0] cur = '1;
    int  w = 0, t = 0, fs_cyc = 0;
    bit  act = 0, done_due = 0, prev_d = 1;

    uart_tx_top #(
        .NB_DATA    (NBD),
        .NB_STOP    (NBS),
        .NC_PER_TICK(NC),
        .NB_COUNTER (NBC)
    ) dut (
        .clk       (clk),
        .i_rst     (rst),
        .i_start_tx(start),
        .i_data    (data),
        .o_data    (o_data),
        .o_txdone  (o_txdone),
        .o_tick    (o_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] frame(input logic [NBD-1:0] d);
        logic [NW-1:0] f;
        f = '1;
        f[0] = 1'b0;
        f[NBD:1] = d;
`ifdef UART_TX_PARITY_EN
        f[NBD+1] = ^d;
`endif
        return f;
    endfunction

    // Monitor: decode frames against the scoreboard using tick count from the frame's first low cycle.
    always @(negedge clk) begin
        if (rst) begin
            act = 0;
            done_due = 0;
        end else begin
            if (done_due) begin
                check("txdone", o_txdone, 1);
                check("txdone_latency_in_range",
                      ((cyc - fs_cyc) >= (T_FRAME - 1) * NC + 1) && ((cyc - fs_cyc) <= T_FRAME * NC), 1);
                done_due = 0;
                done_cnt++;
            end else if (o_txdone) begin
                check("spurious_txdone", o_txdone, 0);
            end
            if (!act && prev_d && !o_data) begin
                check("frame_expected", sb.size() != 0, 1);
                if (sb.size() != 0) cur = sb.pop_front();
                act = 1;
                w = 0;
                t = 0;
                fs_cyc = cyc;
            end
            if (act && o_tick) begin
                t++;
                if (t == 1 || t == ((w == NW - 1) ? NBS : TPB))
                    check($sformatf("bit%0d_t%0d", w, t), o_data, cur[w]);
                if (t == ((w == NW - 1) ? NBS : TPB)) begin
                    t = 0;
                    w++;
                    if (w == NW) begin
                        act = 0;
                        done_due = 1;
                    end
                end
            end
        end
        prev_d = o_data;
    end

    task automatic wait_tick();
        int k = 0;
        while (!o_tick && k < 4 * NC) begin
            @(negedge clk);
            k++;
        end
        if (!o_tick) check("tick_timeout", o_tick, 1);
    endtask

    task automatic send(input logic [NBD-1:0] d);
        @(negedge clk);
        start = 1'b1;
        data = d;
        sb.push_back(frame(d));
        @(negedge clk);
        start = 1'b0;
        data = ~d;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_cnt < n && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        check("done_count", done_cnt, n);
    endtask

    task automatic wait_window(input int wmin);
        int k = 0;
        while (!(act && w >= wmin) && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        check("reached_window", act && w >= wmin, 1);
    endtask

    initial begin
        int c0;
        int k;
        repeat (3) @(negedge clk);
        check("rst_o_data", o_data, 1);
        check("rst_o_txdone", o_txdone, 0);
        check("rst_o_tick", o_tick, 0);
        rst = 1'b0;
        c0 = cyc;
        wait_tick();
        check("first_tick_delay", cyc - c0, NC - 1);
        for (int i = 0; i < 3; i++) begin
            c0 = cyc;
            @(negedge clk);
            check("tick_width", o_tick, 0);
            wait_tick();
            check("tick_period", cyc - c0, NC);
        end

        send(8'hA5);
        wait_done(1);

        send(8'hA5);
        wait_window(4);
        start = 1'b1;
        data = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        wait_done(2);
        check("sb_after_ignored_start", sb.size(), 0);

        send(8'hC3);
        wait_window(3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_o_data", o_data, 1);
        check("abort_o_txdone", o_txdone, 0);
        rst = 1'b0;
        repeat (3 * TPB * NC) @(negedge clk);
        check("abort_no_txdone", done_cnt, 2);
        send(8'h5A);
        wait_done(3);

        send(8'h00);
        k = 0;
        while (!o_txdone && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        check("b2b_first_done_seen", o_txdone, 1);
        start = 1'b1;
        data = 8'hFF;
        sb.push_back(frame(8'hFF));
        @(negedge clk);
        start = 1'b0;
        data = 8'h00;
        check("b2b_no_idle_gap", o_data, 0);
        wait_done(5);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
